// File: rtl/fp_arbiter.sv
// Round-robin arbiter sharing one non-stallable fp_unit among NREQ requesters, with in-order response routing.
// Optional feature macro FP_ARBITER_PERF_EN builds the issue/conflict performance counters.
module fp_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_data1,
  input  logic [NREQ*32-1:0]   req_data2,
  input  logic [NREQ*32-1:0]   req_data3,
  input  logic [NREQ*3-1:0]    req_rm,
  input  logic [NREQ*4-1:0]    req_op,
  output logic                 exe_enable,
  output logic [31:0]          exe_data1,
  output logic [31:0]          exe_data2,
  output logic [31:0]          exe_data3,
  output logic [2:0]           exe_rm,
  output logic [3:0]           exe_op,
  input  logic                 exe_ready,
  input  logic [31:0]          exe_result,
  input  logic [4:0]           exe_flags,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_result,
  output logic [4:0]           rsp_flags,
  output logic                 err,
  output logic [31:0]          perf_issue,
  output logic [31:0]          perf_conflict
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(LATENCY + 1);

  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] op_ok;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_id;
  logic [IW:0]     rr_sum;
  logic [IW-1:0]   rr_sel;
  logic            rr_found;
  logic            bad_op;

  always_comb begin
    op_ok = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_ok[i] = $onehot(req_op[4*i +: 4]);
    end
  end

  assign eligible = req_valid & op_ok;
  assign bad_op   = |(req_valid & ~op_ok);

  // Scan from ptr upward with wrap; the first eligible requester wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    rr_sum   = '0;
    rr_sel   = '0;
    rr_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      rr_sum = {1'b0, ptr} + (IW+1)'(k);
      if (rr_sum >= (IW+1)'(NREQ)) rr_sum = rr_sum - (IW+1)'(NREQ);
      rr_sel = rr_sum[IW-1:0];
      if (!rr_found && eligible[rr_sel]) begin
        rr_found      = 1'b1;
        grant[rr_sel] = 1'b1;
        grant_id      = rr_sel;
      end
    end
    if (!reset) grant = '0;
  end

  assign req_ready  = grant;
  assign exe_enable = |grant;

  always_comb begin
    exe_data1 = '0;
    exe_data2 = '0;
    exe_data3 = '0;
    exe_rm    = '0;
    exe_op    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        exe_data1 = req_data1[32*i +: 32];
        exe_data2 = req_data2[32*i +: 32];
        exe_data3 = req_data3[32*i +: 32];
        exe_rm    = req_rm[3*i +: 3];
        exe_op    = req_op[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr <= '0;
    end else if (exe_enable) begin
      ptr <= (grant_id == IW'(NREQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Tag pipeline mirrors the fp_unit stages; the last stage is the one completing now.
  logic [LATENCY-1:0] tag_vld;
  logic [IW-1:0]      tag_id [LATENCY];

  always_ff @(posedge clock) begin
    if (!reset) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= exe_enable;
      for (int i = 1; i < LATENCY; i++) tag_vld[i] <= tag_vld[i-1];
    end
  end

  always_ff @(posedge clock) begin
    tag_id[0] <= grant_id;
    for (int i = 1; i < LATENCY; i++) tag_id[i] <= tag_id[i-1];
  end

  logic          exit_vld;
  logic [IW-1:0] exit_id;
  logic          rsp_ok;
  logic          tag_err;
  logic [CW-1:0] quiet_cnt;

  assign exit_vld = tag_vld[LATENCY-1];
  assign exit_id  = tag_id[LATENCY-1];
  assign rsp_ok   = reset & exit_vld & exe_ready;

  assign rsp_valid  = rsp_ok ? (NREQ'(1) << exit_id) : '0;
  assign rsp_result = rsp_ok ? exe_result : '0;
  assign rsp_flags  = rsp_ok ? exe_flags : '0;

  // Completions of operations flushed by reset may still arrive for LATENCY cycles.
  always_ff @(posedge clock) begin
    if (!reset) begin
      quiet_cnt <= CW'(LATENCY);
    end else if (quiet_cnt != '0) begin
      quiet_cnt <= quiet_cnt - 1'b1;
    end
  end

  assign tag_err = (exit_vld & ~exe_ready) | (exe_ready & ~exit_vld & (quiet_cnt == '0));

  always_ff @(posedge clock) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (tag_err | bad_op) begin
      err <= 1'b1;
    end
  end

`ifdef FP_ARBITER_PERF_EN
  logic [31:0] issue_cnt;
  logic [31:0] conflict_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      issue_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (exe_enable) issue_cnt <= issue_cnt + 32'd1;
      if ($countones(req_valid) > 1) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  assign perf_issue    = issue_cnt;
  assign perf_conflict = conflict_cnt;
`else
  assign perf_issue    = '0;
  assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_fp_arbiter.sv
// Bench for fp_arbiter: a fixed-latency fp_unit stand-in plus a grant/response scoreboard.
module tb_fp_arbiter;

  localparam int NREQ    = 4;
  localparam int LATENCY = 3;
  typedef logic [56:0] ent_t;  // {cycle[15:0], rsp_valid[3:0], flags[4:0], result[31:0]}

  logic                clock = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_data1, req_data2, req_data3;
  logic [NREQ*3-1:0]   req_rm;
  logic [NREQ*4-1:0]   req_op;
  logic                exe_enable;
  logic [31:0]         exe_data1, exe_data2, exe_data3;
  logic [2:0]          exe_rm;
  logic [3:0]          exe_op;
  logic                exe_ready;
  logic [31:0]         exe_result;
  logic [4:0]          exe_flags;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_result;
  logic [4:0]          rsp_flags;
  logic                err;
  logic [31:0]         perf_issue, perf_conflict;

  logic [31:0] d1 [NREQ];
  logic [31:0] d2 [NREQ];
  logic [31:0] d3 [NREQ];
  logic [2:0]  rm [NREQ];
  logic [3:0]  op [NREQ];
  logic        force_low = 1'b0;

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t exp_q[$];
  ent_t rsp_q[$];

  fp_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
    .req_rm(req_rm), .req_op(req_op),
    .exe_enable(exe_enable), .exe_data1(exe_data1), .exe_data2(exe_data2), .exe_data3(exe_data3),
    .exe_rm(exe_rm), .exe_op(exe_op),
    .exe_ready(exe_ready), .exe_result(exe_result), .exe_flags(exe_flags),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .err(err), .perf_issue(perf_issue), .perf_conflict(perf_conflict)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always_comb begin
    req_data1 = '0;
    req_data2 = '0;
    req_data3 = '0;
    req_rm    = '0;
    req_op    = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_data1[32*i +: 32] = d1[i];
      req_data2[32*i +: 32] = d2[i];
      req_data3[32*i +: 32] = d3[i];
      req_rm[3*i +: 3]      = rm[i];
      req_op[4*i +: 4]      = op[i];
    end
  end

  // fp_unit stand-in: exact 1.0+2.0 for the fadd case, otherwise a deterministic operand hash.
  function automatic logic [36:0] fpu(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                      input logic [2:0] m, input logic [3:0] o);
    logic [31:0] r;
    if (o == 4'b0100 && a == 32'h3F800000 && b == 32'h40000000 && m == 3'd0) return {5'd0, 32'h40400000};
    r = a ^ {b[15:0], b[31:16]} ^ (c + {25'd0, m, o});
    return {r[31:27] ^ r[4:0], r};
  endfunction

  logic        stub_vld [LATENCY] = '{default: 1'b0};
  logic [36:0] stub_res [LATENCY];

  always @(posedge clock) begin
    stub_vld[0] <= exe_enable;
    stub_res[0] <= fpu(exe_data1, exe_data2, exe_data3, exe_rm, exe_op);
    for (int i = 1; i < LATENCY; i++) begin
      stub_vld[i] <= stub_vld[i-1];
      stub_res[i] <= stub_res[i-1];
    end
  end

  assign exe_ready  = stub_vld[LATENCY-1] & ~force_low;
  assign exe_result = stub_res[LATENCY-1][31:0];
  assign exe_flags  = stub_res[LATENCY-1][36:32];

  // Expected responses are queued at grant time from the requester's own fields.
  always @(negedge clock) begin
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) exp_q.push_back({16'(cyc + LATENCY), 4'(1 << i), fpu(d1[i], d2[i], d3[i], rm[i], op[i])});
    end
    if (rsp_valid != '0) rsp_q.push_back({16'(cyc), rsp_valid, rsp_flags, rsp_result});
  end

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [2:0] m, input logic [3:0] o);
    d1[i] = a; d2[i] = b; d3[i] = c; rm[i] = m; op[i] = o;
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b0;
    req_valid = '0;
    repeat (n) next();
    reset = 1'b1;
    exp_q.delete();
    rsp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h1000 + i, 32'h2000 + i, 32'h3000 + i, 3'(i), 4'(1 << i));
    req_valid = '1;
    next(); next();
    @(negedge clock);
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    n_checks++; if (exe_enable !== 1'b0) begin n_fail++; $display("FAIL reset_exe_enable got=%b want=0", exe_enable); end
    n_checks++; if (exe_data1 !== 32'd0) begin n_fail++; $display("FAIL reset_exe_data1 got=%h want=0", exe_data1); end
    n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b want=0000", rsp_valid); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b want=0", err); end
    n_checks++; if (perf_issue !== 32'd0) begin n_fail++; $display("FAIL reset_perf_issue got=%0d want=0", perf_issue); end
    n_checks++; if (perf_conflict !== 32'd0) begin n_fail++; $display("FAIL reset_perf_conflict got=%0d want=0", perf_conflict); end
    next();
    req_valid = '0;
    reset     = 1'b1;
    exp_q.delete();
    rsp_q.delete();
  endtask

  task automatic test_single();
    ent_t o, e;
    set_req(2, 32'h3F800000, 32'h40000000, 32'd0, 3'd0, 4'b0100);
    req_valid = 4'b0100;
    @(negedge clock);
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got=%b want=0100", req_ready); end
    n_checks++; if (exe_enable !== 1'b1) begin n_fail++; $display("FAIL single_exe_enable got=%b want=1", exe_enable); end
    n_checks++; if (exe_data1 !== 32'h3F800000) begin n_fail++; $display("FAIL single_exe_data1 got=%h want=3f800000", exe_data1); end
    n_checks++; if (exe_data2 !== 32'h40000000) begin n_fail++; $display("FAIL single_exe_data2 got=%h want=40000000", exe_data2); end
    n_checks++; if (exe_op !== 4'b0100) begin n_fail++; $display("FAIL single_exe_op got=%b want=0100", exe_op); end
    next();
    req_valid = '0;
    for (int k = 1; k < LATENCY; k++) begin
      @(negedge clock);
      n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL single_early_rsp cycle+%0d got=%b want=0000", k, rsp_valid); end
      n_checks++; if (exe_data1 !== 32'd0) begin n_fail++; $display("FAIL single_idle_data1 got=%h want=0", exe_data1); end
      next();
    end
    @(negedge clock);
    n_checks++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_valid got=%b want=0100", rsp_valid); end
    n_checks++; if (rsp_result !== 32'h40400000) begin n_fail++; $display("FAIL single_rsp_result got=%h want=40400000", rsp_result); end
    n_checks++; if (rsp_flags !== 5'd0) begin n_fail++; $display("FAIL single_rsp_flags got=%b want=00000", rsp_flags); end
    repeat (3) next();
    n_checks++; if (rsp_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_rsp_count got=%0d want=%0d", rsp_q.size(), exp_q.size()); end
    while (rsp_q.size() > 0 && exp_q.size() > 0) begin
      o = rsp_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL single_rsp got=%h want=%h", o, e); end
    end
    exp_q.delete(); rsp_q.delete();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err got=%b want=0", err); end
  endtask

  task automatic test_round_robin();
    ent_t o, e;
    logic [3:0] want;
    do_reset(1);
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom, $urandom, 3'(i + 1), 4'(1 << (3 - i)));
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      want = 4'(1 << (k % 4));
      n_checks++; if (req_ready !== want) begin n_fail++; $display("FAIL rr_grant step %0d got=%b want=%b", k, req_ready, want); end
      next();
    end
    req_valid = '0;
    repeat (LATENCY + 1) next();
    n_checks++; if (rsp_q.size() != 8) begin n_fail++; $display("FAIL rr_rsp_count got=%0d want=8", rsp_q.size()); end
    while (rsp_q.size() > 0 && exp_q.size() > 0) begin
      o = rsp_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL rr_rsp got=%h want=%h", o, e); end
    end
    exp_q.delete(); rsp_q.delete();
`ifdef FP_ARBITER_PERF_EN
    n_checks++; if (perf_conflict !== 32'd8) begin n_fail++; $display("FAIL rr_perf_conflict got=%0d want=8", perf_conflict); end
    n_checks++; if (perf_issue !== 32'd8) begin n_fail++; $display("FAIL rr_perf_issue got=%0d want=8", perf_issue); end
`else
    n_checks++; if (perf_conflict !== 32'd0) begin n_fail++; $display("FAIL rr_perf_conflict got=%0d want=0", perf_conflict); end
    n_checks++; if (perf_issue !== 32'd0) begin n_fail++; $display("FAIL rr_perf_issue got=%0d want=0", perf_issue); end
`endif
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rr_err got=%b want=0", err); end
  endtask

  task automatic test_skip();
    ent_t o, e;
    logic [3:0] want;
    req_valid = 4'b0010;
    @(negedge clock);
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL skip_prime got=%b want=0010", req_ready); end
    next();
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      want = (k % 2 == 0) ? 4'b1000 : 4'b0010;
      n_checks++; if (req_ready !== want) begin n_fail++; $display("FAIL skip_grant step %0d got=%b want=%b", k, req_ready, want); end
      next();
    end
    req_valid = '0;
    repeat (LATENCY + 1) next();
    n_checks++; if (rsp_q.size() != 5) begin n_fail++; $display("FAIL skip_rsp_count got=%0d want=5", rsp_q.size()); end
    while (rsp_q.size() > 0 && exp_q.size() > 0) begin
      o = rsp_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL skip_rsp got=%h want=%h", o, e); end
    end
    exp_q.delete(); rsp_q.delete();
  endtask

  task automatic test_ready_drop();
    req_valid = 4'b0001;
    force_low = 1'b1;
    @(negedge clock);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL drop_grant got=%b want=0001", req_ready); end
    next();
    req_valid = '0;
    repeat (LATENCY - 1) next();
    @(negedge clock);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL drop_err_before got=%b want=0", err); end
    n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL drop_rsp_valid got=%b want=0000", rsp_valid); end
    n_checks++; if (rsp_result !== 32'd0) begin n_fail++; $display("FAIL drop_rsp_result got=%h want=0", rsp_result); end
    next();
    force_low = 1'b0;
    @(negedge clock);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL drop_err got=%b want=1", err); end
    n_checks++; if (rsp_q.size() != 0) begin n_fail++; $display("FAIL drop_rsp_count got=%0d want=0", rsp_q.size()); end
    exp_q.delete(); rsp_q.delete();
    next();
  endtask

  task automatic test_bad_op();
    do_reset(1);
    set_req(0, 32'h11111111, 32'h22222222, 32'h33333333, 3'd1, 4'b0011);
    req_valid = 4'b0001;
    @(negedge clock);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL badop_err_cleared got=%b want=0", err); end
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL badop_grant got=%b want=0000", req_ready); end
    next();
    @(negedge clock);
    n_checks++; if (exe_enable !== 1'b0) begin n_fail++; $display("FAIL badop_exe_enable got=%b want=0", exe_enable); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL badop_err got=%b want=1", err); end
    next();
    req_valid = '0;
    set_req(0, 32'h11111111, 32'h22222222, 32'h33333333, 3'd1, 4'b0001);
    repeat (6) next();
    @(negedge clock);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL badop_err_sticky got=%b want=1", err); end
    next();
  endtask

  task automatic test_reset_inflight();
    ent_t o, e;
    set_req(1, 32'hA5A50001, 32'h5A5A0001, 32'h0F0F0001, 3'd2, 4'b0010);
    set_req(2, 32'hA5A50002, 32'h5A5A0002, 32'h0F0F0002, 3'd3, 4'b1000);
    req_valid = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      n_checks++; if (exe_enable !== 1'b1) begin n_fail++; $display("FAIL inflight_issue %0d got=%b want=1", k, exe_enable); end
      next();
    end
    do_reset(1);
    for (int k = 0; k < LATENCY + 2; k++) begin
      @(negedge clock);
      n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL inflight_rsp step %0d got=%b want=0000", k, rsp_valid); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL inflight_err step %0d got=%b want=0", k, err); end
      next();
    end
    n_checks++; if (rsp_q.size() != 0) begin n_fail++; $display("FAIL inflight_rsp_count got=%0d want=0", rsp_q.size()); end
    req_valid = 4'hF;
    @(negedge clock);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL inflight_next_grant got=%b want=0001", req_ready); end
    next();
    req_valid = '0;
    repeat (LATENCY + 1) next();
    n_checks++; if (rsp_q.size() != 1) begin n_fail++; $display("FAIL inflight_post_count got=%0d want=1", rsp_q.size()); end
    while (rsp_q.size() > 0 && exp_q.size() > 0) begin
      o = rsp_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL inflight_rsp got=%h want=%h", o, e); end
    end
    exp_q.delete(); rsp_q.delete();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL inflight_final_err got=%b want=0", err); end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'd0, 32'd0, 32'd0, 3'd0, 4'b0001);
    test_reset();
    test_single();
    test_round_robin();
    test_skip();
    test_ready_drop();
    test_bad_op();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
